// File: rtl/fe_bp_ctrl_if.sv
// Fetch-stage next-PC bundle between the FE/AGEX pipeline and the branch-predictor controller.
// Latency: none; this file only groups wires.
// Backpressure: none; flush overrides the FE stall, and AGEX resolutions are dropped while the controller is busy.
//
// Ports:
//   Pipeline side (master) drives fe_pc and the agex_* resolution fields.
//   Controller side (slave) drives bp_pc, flush, pred_taken and busy.
interface fe_bp_ctrl_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] fe_pc;
  logic             agex_valid;
  logic [DBITS-1:0] agex_pc;
  logic             agex_taken;
  logic [DBITS-1:0] agex_target;
  logic             agex_pred_taken;
  logic [DBITS-1:0] agex_pred_target;
  logic [DBITS-1:0] bp_pc;
  logic             flush;
  logic             pred_taken;
  logic             busy;

  modport master (
    output fe_pc, agex_valid, agex_pc, agex_taken, agex_target,
           agex_pred_taken, agex_pred_target,
    input  bp_pc, flush, pred_taken, busy
  );

  modport slave (
    input  fe_pc, agex_valid, agex_pc, agex_taken, agex_target,
           agex_pred_taken, agex_pred_target,
    output bp_pc, flush, pred_taken, busy
  );
endinterface

// File: rtl/fe_bp_ctrl.sv
// Next-PC controller: direct-mapped BTB with 2-bit counters, trained by AGEX, plus a redirect/squash sequencer.
// Latency: bp_pc/pred_taken are combinational from fe_pc; a mispredict drives flush on the next cycle, and the next resolution is accepted 1+SQUASH_CYCLES cycles after that.
// Backpressure: none; AGEX resolutions arriving in REDIR or SQUASH are dropped (wrong path).
//
// Ports:
//   clk, reset   rising-edge clock; asynchronous active-low reset
//   bus (slave)  fe_pc/agex_* in; bp_pc, flush, pred_taken, busy out
//   stat_branches, stat_mispredicts  32-bit wrapping counters, present only when FE_BP_CTRL_STATS_EN is defined
module fe_bp_ctrl #(
  parameter int DBITS         = 32,
  parameter int BTB_IDX_BITS  = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  fe_bp_ctrl_if.slave bus
`ifdef FE_BP_CTRL_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W   = DBITS - BTB_IDX_BITS - 2;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_REDIR  = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

  // BTB storage: valid and counters are reset; tag/target of invalid entries are don't-care.
  logic                    btb_vld [ENTRIES];
  logic [1:0]              btb_ctr [ENTRIES];
  logic [TAG_W-1:0]        btb_tag [ENTRIES];
  logic [DBITS-1:0]        btb_tgt [ENTRIES];

  logic [1:0]              state;
  logic [2:0]              sq_cnt;
  logic [DBITS-1:0]        redir_pc;

  // Fetch-side lookup.
  logic [BTB_IDX_BITS-1:0] fe_idx;
  logic [TAG_W-1:0]        fe_tag;
  logic                    fe_hit;
  logic                    lk_taken;
  logic [DBITS-1:0]        fe_seq;

  assign fe_idx   = bus.fe_pc[BTB_IDX_BITS+1:2];
  assign fe_tag   = bus.fe_pc[DBITS-1:BTB_IDX_BITS+2];
  assign fe_hit   = btb_vld[fe_idx] && (btb_tag[fe_idx] == fe_tag);
  assign lk_taken = fe_hit && btb_ctr[fe_idx][1];
  assign fe_seq   = bus.fe_pc + DBITS'(4);

  always_comb begin
    bus.flush      = 1'b0;
    bus.busy       = (state != ST_RUN);
    bus.pred_taken = lk_taken;
    bus.bp_pc      = lk_taken ? btb_tgt[fe_idx] : fe_seq;
    if (state == ST_REDIR) begin
      bus.flush      = 1'b1;
      bus.pred_taken = 1'b0;
      bus.bp_pc      = redir_pc;
    end
  end

  // AGEX resolution side.
  logic [BTB_IDX_BITS-1:0] ag_idx;
  logic [TAG_W-1:0]        ag_tag;
  logic                    ag_hit;
  logic                    accept;
  logic                    mispred;
  logic [DBITS-1:0]        correct_pc;
  logic [1:0]              ctr_cur;
  logic [1:0]              ctr_inc;
  logic [1:0]              ctr_dec;

  assign ag_idx     = bus.agex_pc[BTB_IDX_BITS+1:2];
  assign ag_tag     = bus.agex_pc[DBITS-1:BTB_IDX_BITS+2];
  assign ag_hit     = btb_vld[ag_idx] && (btb_tag[ag_idx] == ag_tag);
  assign accept     = bus.agex_valid && (state == ST_RUN);
  assign mispred    = accept &&
                      ((bus.agex_taken != bus.agex_pred_taken) ||
                       (bus.agex_taken && (bus.agex_target != bus.agex_pred_target)));
  assign correct_pc = bus.agex_taken ? bus.agex_target : (bus.agex_pc + DBITS'(4));
  assign ctr_cur    = btb_ctr[ag_idx];
  assign ctr_inc    = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
  assign ctr_dec    = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;

  // Valid bits and counters. A taken miss allocates weakly-taken; a not-taken miss leaves the entry alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_vld[i] <= 1'b0;
        btb_ctr[i] <= 2'b01;
      end
    end else if (accept) begin
      if (bus.agex_taken) begin
        btb_vld[ag_idx] <= 1'b1;
        btb_ctr[ag_idx] <= ag_hit ? ctr_inc : 2'b10;
      end else if (ag_hit) begin
        btb_ctr[ag_idx] <= ctr_dec;
      end
    end
  end

  // Tag/target payload carries no reset.
  always_ff @(posedge clk) begin
    if (accept && bus.agex_taken) begin
      btb_tag[ag_idx] <= ag_tag;
      btb_tgt[ag_idx] <= bus.agex_target;
    end
  end

  // Redirect sequencer: one flush cycle, then SQUASH_CYCLES cycles of ignoring AGEX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      sq_cnt   <= 3'd0;
      redir_pc <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mispred) begin
            state    <= ST_REDIR;
            redir_pc <= correct_pc;
          end
        end
        ST_REDIR: begin
          state  <= ST_SQUASH;
          sq_cnt <= 3'(SQUASH_CYCLES);
        end
        ST_SQUASH: begin
          if (sq_cnt <= 3'd1) begin
            state  <= ST_RUN;
            sq_cnt <= 3'd0;
          end else begin
            sq_cnt <= sq_cnt - 3'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef FE_BP_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (accept)  stat_branches    <= stat_branches + 32'd1;
      if (mispred) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fe_bp_ctrl.sv
// Directed bench for fe_bp_ctrl: scoreboard queue of expected fetch outputs, checked with immediate assertions.
// Latency: expected values are compared at the falling edge of the cycle they were driven in.
// Backpressure: not applicable.
module tb_fe_bp_ctrl;

  logic clk;
  logic reset;

  fe_bp_ctrl_if #(.DBITS(32)) bus ();

`ifdef FE_BP_CTRL_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  fe_bp_ctrl #(
    .DBITS(32),
    .BTB_IDX_BITS(4),
    .SQUASH_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FE_BP_CTRL_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] bp_pc;
    logic        flush;
    logic        pred_taken;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic drive(input logic [31:0] fe, input logic av, input logic [31:0] apc,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    bus.fe_pc            = fe;
    bus.agex_valid       = av;
    bus.agex_pc          = apc;
    bus.agex_taken       = tk;
    bus.agex_target      = tgt;
    bus.agex_pred_taken  = ptk;
    bus.agex_pred_target = ptgt;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] bp, input logic fl,
                            input logic pt, input logic bz);
    exp_t e;
    e.tag = tag; e.bp_pc = bp; e.flush = fl; e.pred_taken = pt; e.busy = bz;
    sb_q.push_back(e);
  endtask

  task automatic cmp_val(input string tag, input string field,
                         input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, got, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    n_cmp++;
    assert (sb_q.size() != 0) else begin
      n_err++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      cmp_val(e.tag, "bp_pc", bus.bp_pc, e.bp_pc);
      cmp_val(e.tag, "flush", 32'(bus.flush), 32'(e.flush));
      cmp_val(e.tag, "pred_taken", 32'(bus.pred_taken), 32'(e.pred_taken));
      cmp_val(e.tag, "busy", 32'(bus.busy), 32'(e.busy));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN-style cycle: drive, expect, sample at the falling edge, advance past the next rising edge.
  task automatic step(input string tag,
                      input logic [31:0] fe, input logic av, input logic [31:0] apc,
                      input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt,
                      input logic [31:0] ebp, input logic efl, input logic ept, input logic ebz);
    drive(fe, av, apc, tk, tgt, ptk, ptgt);
    expect_out(tag, ebp, efl, ept, ebz);
    @(negedge clk);
    compare_out();
    tick();
  endtask

  initial begin
    int cyc;

    reset = 1'b0;
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("rst_hold", 32'h104, 1'b0, 1'b0, 1'b0);
    #2;
    compare_out();
`ifdef FE_BP_CTRL_STATS_EN
    cmp_val("rst_hold", "stat_branches", stat_branches, 32'd0);
    cmp_val("rst_hold", "stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    //         tag           fe_pc          av    agex_pc   tk    target    ptk   ptarget    bp_pc          fl    pt    busy
    step("idle_100",     32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h104,       1'b0, 1'b0, 1'b0);
    step("wrap",         32'hFFFF_FFFC, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h0,         1'b0, 1'b0, 1'b0);
    // Cold taken branch at 0x100 mispredicted: redirect to 0x80.
    step("cold_mis",     32'h104,       1'b1, 32'h100,  1'b1, 32'h80,   1'b0, 32'h0,     32'h108,       1'b0, 1'b0, 1'b0);
    step("redir_80",     32'h108,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h80,        1'b1, 1'b0, 1'b1);
    // Wrong-path resolutions for 0x200 during the squash window are dropped.
    step("squash_1",     32'h80,        1'b1, 32'h200,  1'b1, 32'h300,  1'b0, 32'h0,     32'h84,        1'b0, 1'b0, 1'b1);
    step("squash_2",     32'h200,       1'b1, 32'h200,  1'b1, 32'h300,  1'b0, 32'h0,     32'h204,       1'b0, 1'b0, 1'b1);
    step("no_alloc_200", 32'h200,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h204,       1'b0, 1'b0, 1'b0);
    step("hit_100_w",    32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h80,        1'b0, 1'b1, 1'b0);
    // Three correct taken resolutions saturate the counter at 11.
    step("train_t1",     32'h100,       1'b1, 32'h100,  1'b1, 32'h80,   1'b1, 32'h80,    32'h80,        1'b0, 1'b1, 1'b0);
    step("train_t2",     32'h100,       1'b1, 32'h100,  1'b1, 32'h80,   1'b1, 32'h80,    32'h80,        1'b0, 1'b1, 1'b0);
    step("train_t3",     32'h100,       1'b1, 32'h100,  1'b1, 32'h80,   1'b1, 32'h80,    32'h80,        1'b0, 1'b1, 1'b0);
    // Not-taken while predicted taken: counter 11->10 and redirect to the fall-through.
    step("nt_mis",       32'h100,       1'b1, 32'h100,  1'b0, 32'h0,    1'b1, 32'h80,    32'h80,        1'b0, 1'b1, 1'b0);
    step("redir_104",    32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h104,       1'b1, 1'b0, 1'b1);
    step("sq_ctr10_a",   32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h80,        1'b0, 1'b1, 1'b1);
    step("sq_ctr10_b",   32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h80,        1'b0, 1'b1, 1'b1);
    step("ctr10_taken",  32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h80,        1'b0, 1'b1, 1'b0);
    // Second not-taken (no mispredict): lookup in the same cycle still sees 10, afterwards 01.
    step("nt_same_cyc",  32'h100,       1'b1, 32'h100,  1'b0, 32'h0,    1'b0, 32'h0,     32'h80,        1'b0, 1'b1, 1'b0);
    step("ctr01_nt",     32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h104,       1'b0, 1'b0, 1'b0);
    // Right direction, wrong target: redirect to 0x90 and retarget the entry.
    step("tgt_mis",      32'h104,       1'b1, 32'h100,  1'b1, 32'h90,   1'b1, 32'h80,    32'h108,       1'b0, 1'b0, 1'b0);
    step("redir_90",     32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h90,        1'b1, 1'b0, 1'b1);

    // Bounded wait for the squash window to close; its length must be SQUASH_CYCLES.
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      cyc++;
    end
    cmp_val("squash_len", "cycles", 32'(cyc), 32'd2);
    tick();

    step("hit_90",       32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h90,        1'b0, 1'b1, 1'b0);
    step("nt_mis2",      32'h100,       1'b1, 32'h100,  1'b0, 32'h0,    1'b1, 32'h90,    32'h90,        1'b0, 1'b1, 1'b0);

    // In REDIR: check the redirect, then pull reset mid-cycle.
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("redir_pre_rst", 32'h104, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    compare_out();
`ifdef FE_BP_CTRL_STATS_EN
    cmp_val("pre_rst", "stat_branches", stat_branches, 32'd8);
    cmp_val("pre_rst", "stat_mispredicts", stat_mispredicts, 32'd4);
`endif
    #1;
    reset = 1'b0;
    expect_out("rst_in_redir", 32'h104, 1'b0, 1'b0, 1'b0);
    #1;
    compare_out();
`ifdef FE_BP_CTRL_STATS_EN
    cmp_val("rst_in_redir", "stat_branches", stat_branches, 32'd0);
    cmp_val("rst_in_redir", "stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    tick();
    reset = 1'b1;
    step("post_rst_100", 32'h100,       1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,     32'h104,       1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fe_bp_ctrl.md
Name: fe_bp_ctrl

Overview:
- Next-PC controller and branch predictor for the fetch stage.
- Each cycle it takes the FE PC and drives the next fetch PC plus a flush/redirect strobe; FE consumes these as {flush, bp_pc}.
- Predicts from a direct-mapped BTB with 2-bit saturating counters.
- Trains on branch resolutions from AGEX.
- On a misprediction it sequences a redirect, then a squash window in which wrong-path resolutions are ignored.

Parameters:
- DBITS, 32, address/data width.
- BTB_IDX_BITS, 4, log2 of BTB entries (16).
- SQUASH_CYCLES, 2, cycles after redirect during which agex_valid is ignored (1..7).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fe_pc  in  DBITS  PC currently in the FE PC latch.
- agex_valid  in  1  a branch/jump resolves in AGEX this cycle.
- agex_pc  in  DBITS  PC of the resolving branch.
- agex_taken  in  1  actual direction.
- agex_target  in  DBITS  actual taken target.
- agex_pred_taken  in  1  direction predicted at fetch, carried down the pipe.
- agex_pred_target  in  DBITS  target predicted at fetch.
- bp_pc  out  DBITS  next fetch PC.
- flush  out  1  squash FE latch and load bp_pc regardless of FE stall.
- pred_taken  out  1  prediction for fe_pc; FE carries it down the pipe.
- busy  out  1  high while in REDIR or SQUASH.

Behaviour:
- Indexing: idx = pc[BTB_IDX_BITS+1:2]; tag = pc[DBITS-1:BTB_IDX_BITS+2]. Each entry holds valid, tag, target and a 2-bit counter.
- Reset (async, reset==0):
  - all valid bits 0, all counters 2'b01, state RUN, squash counter 0, redirect register 0.
  - flush=0, busy=0, pred_taken=0.
  - bp_pc = fe_pc+4 (combinational).
- Lookup (combinational, RUN and SQUASH):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - bp_pc = pred_taken ? target[idx] : fe_pc+4, with modulo-2^DBITS wrap.
- Mispredict (combinational, only when accepted):
  - Condition: agex_valid && (agex_taken != agex_pred_taken || (agex_taken && agex_target != agex_pred_target)).
  - Correct PC = agex_taken ? agex_target : agex_pc+4.
- Acceptance: agex_valid is accepted only in state RUN. In REDIR and SQUASH it is ignored: no training, no mispredict.
- Training (at the clock edge on each accepted agex_valid):
  - Counter: increment if taken, decrement if not; saturate at 2'b00 and 2'b11.
  - Taken branch: write tag, target and valid.
  - Not-taken branch that misses: no allocation and no counter change.
  - Taken branch that misses (new allocation): counter written as 2'b10.
- FSM:
  - RUN -> REDIR on an accepted mispredict. The correct PC is latched into the redirect register.
  - REDIR (exactly 1 cycle): flush=1, bp_pc = redirect register, pred_taken=0, busy=1. Then -> SQUASH with counter = SQUASH_CYCLES.
  - SQUASH: flush=0, busy=1; counter decrements each cycle. At the cycle where it reaches 1 -> RUN.
  - Redirect-to-next-accepted-resolution latency is 1+SQUASH_CYCLES cycles.
- Same cycle lookup and update to the same idx: lookup sees pre-edge contents; the write lands at the edge.
- Reset asserted mid-REDIR/SQUASH: immediately returns to RUN with flush=0. The BTB is cleared.
- No sync reset of the BTB contents other than the valid bits; the target/tag of invalid entries are don't-care.

Optional Feature:
- Macro: FE_BP_CTRL_STATS_EN.
- Defined: adds outputs stat_branches and stat_mispredicts (32-bit each, wrap at 2^32).
  - stat_branches increments on every accepted agex_valid.
  - stat_mispredicts increments on every accepted mispredict.
  - Both reset to 0 asynchronously.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset to 0, release, fe_pc=0x100 -> bp_pc=0x104, pred_taken=0, flush=0, busy=0.
- Cold branch at agex_pc=0x100: taken, target 0x80, pred_taken=0 -> next cycle flush=1, bp_pc=0x80. Then busy=1 for 2 more cycles, then busy=0. Afterwards fe_pc=0x100 -> pred_taken=1, bp_pc=0x80 (counter 10).
- During the squash window after a redirect: agex_valid=1 with a mismatch on pc 0x200 -> no flush, BTB entry for 0x200 stays invalid.
- Branch at 0x100 trained taken 3x (predicted correctly) then not-taken -> counter 11 to 10; still predicts taken. A second not-taken gives 01 -> fe_pc=0x100 yields bp_pc=0x104.
- Correct prediction with wrong target: agex_pred_target=0x80, agex_target=0x90 -> flush, bp_pc=0x90, BTB target updated to 0x90.
- Assert reset low during REDIR -> flush drops the same cycle, busy=0, a previously trained 0x100 now predicts 0x104; with STATS_EN both stats read 0.
